// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two previous lines and emits each fully
// populated neighbourhood (no border padding) with a one-cycle valid strobe.
module sobel_window_gen #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned LINE_LEN    = 32,
    parameter int unsigned FRAME_ROWS  = 32
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     start_i,
    input  logic                     px_valid_i,
    input  logic [PIXEL_WIDTH-1:0]   px_i,
    output logic [9*PIXEL_WIDTH-1:0] window_o,
    output logic                     window_valid_o,
    output logic                     frame_done_o
);

    localparam int unsigned COL_W = $clog2(LINE_LEN);
    localparam int unsigned ROW_W = $clog2(FRAME_ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);

    logic [COL_W-1:0]         col_q;
    logic [ROW_W-1:0]         row_q;
    logic [PIXEL_WIDTH-1:0]   line0_q [LINE_LEN];
    logic [PIXEL_WIDTH-1:0]   line1_q [LINE_LEN];
    logic [9*PIXEL_WIDTH-1:0] win_q;
    logic [9*PIXEL_WIDTH-1:0] win_d;
    logic [9*PIXEL_WIDTH-1:0] window_q;
    logic                     valid_q;
    logic                     done_q;
    logic                     accept;
    logic                     col_last;
    logic                     row_last;
    logic                     win_ready;

    assign accept    = px_valid_i && !start_i;
    assign col_last  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    assign win_ready = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // Shift the window left by one column; the new right column is {line1, line0, px}.
    always_comb begin
        win_d = win_q;
        for (int unsigned r = 0; r < 3; r++) begin
            win_d[(3*r)*PIXEL_WIDTH +: PIXEL_WIDTH]   = win_q[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH];
            win_d[(3*r+1)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_q[(3*r+2)*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        win_d[2*PIXEL_WIDTH +: PIXEL_WIDTH] = line1_q[col_q];
        win_d[5*PIXEL_WIDTH +: PIXEL_WIDTH] = line0_q[col_q];
        win_d[8*PIXEL_WIDTH +: PIXEL_WIDTH] = px_i;
    end

    // Line storage is never observed before being rewritten, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            line1_q[col_q] <= line0_q[col_q];
            line0_q[col_q] <= px_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (px_valid_i) begin
                win_q <= win_d;
                if (win_ready) begin
                    window_q <= win_d;
                    valid_q  <= 1'b1;
                end
                if (col_last) begin
                    col_q <= '0;
                    if (row_last) begin
                        row_q  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

    assign window_o       = window_q;
    assign window_valid_o = valid_q;
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: image-array model checked every cycle, plus literal
// window/count expectations for the directed scenarios.
module tb_sobel_window_gen;

    localparam int unsigned PW = 8;
    localparam int unsigned LL = 4;
    localparam int unsigned FR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          px_valid = 1'b0;
    logic [PW-1:0] px = '0;
    logic [9*PW-1:0] window;
    logic          window_valid;
    logic          frame_done;

    sobel_window_gen #(
        .PIXEL_WIDTH(PW),
        .LINE_LEN   (LL),
        .FRAME_ROWS (FR)
    ) dut (
        .clk_i         (clk),
        .nreset_i      (rst_n),
        .start_i       (start),
        .px_valid_i    (px_valid),
        .px_i          (px),
        .window_o      (window),
        .window_valid_o(window_valid),
        .frame_done_o  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [71:0] pack9(input int v0, input int v1, input int v2,
                                          input int v3, input int v4, input int v5,
                                          input int v6, input int v7, input int v8);
        int a [9];
        logic [71:0] w;
        a = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        w = '0;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(a[k]);
        return w;
    endfunction

    // Model: remember the image by position, emit the 3x3 block ending at each pixel.
    int          img [FR][LL];
    int          mr = 0;
    int          mc = 0;
    logic        exp_valid = 1'b0;
    logic        exp_done = 1'b0;
    logic [71:0] exp_win = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mr = 0; mc = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0;
            end else begin
                exp_valid = 1'b0;
                exp_done  = 1'b0;
                if (start) begin
                    mr = 0; mc = 0;
                end else if (px_valid) begin
                    img[mr][mc] = int'(px);
                    if (mr >= 2 && mc >= 2) begin
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                exp_win[(3*r+c)*8 +: 8] = 8'(img[mr-2+r][mc-2+c]);
                        exp_valid = 1'b1;
                    end
                    mc++;
                    if (mc == LL) begin
                        mc = 0;
                        mr++;
                        if (mr == FR) begin
                            mr = 0;
                            exp_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    int          n_win = 0;
    int          n_done = 0;
    logic [71:0] seen [$];

    initial begin
        forever begin
            @(negedge clk);
            check("window_valid", 72'(window_valid), 72'(exp_valid));
            check("frame_done", 72'(frame_done), 72'(exp_done));
            check("window", window, exp_win);
            if (window_valid) begin
                n_win++;
                seen.push_back(window);
            end
            if (frame_done) n_done++;
        end
    end

    task automatic drive(input logic v, input logic s, input logic [PW-1:0] p);
        px_valid = v;
        start    = s;
        px       = p;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int base, input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) while ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, PW'($urandom));
            drive(1'b1, 1'b0, PW'(base + i));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic clear_counts();
        n_win = 0;
        n_done = 0;
        seen.delete();
    endtask

    logic [71:0] t1 [4];

    task automatic check_frame(input string tag);
        check({tag, "_count"}, 72'(n_win), 72'(4));
        check({tag, "_done"}, 72'(n_done), 72'(1));
        for (int k = 0; k < 4; k++) check({tag, "_win"}, seen[k], t1[k]);
    endtask

    initial begin
        t1[0] = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        t1[1] = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        t1[2] = pack9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        t1[3] = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);

        repeat (2) @(posedge clk);
        #1;
        check("reset_window", window, '0);
        check("reset_valid", 72'(window_valid), 72'(0));
        check("reset_done", 72'(frame_done), 72'(0));
        rst_n = 1'b1;
        idle(2);

        // 1: back-to-back frame
        clear_counts();
        stream(0, 0, 15, 1'b0);
        idle(3);
        check_frame("t1");

        // 2: random gaps
        clear_counts();
        stream(0, 0, 15, 1'b1);
        idle(3);
        check_frame("t2");

        // 3: two frames back-to-back
        clear_counts();
        stream(0, 0, 15, 1'b0);
        stream(100, 0, 15, 1'b0);
        idle(3);
        check("t3_count", 72'(n_win), 72'(8));
        check("t3_done", 72'(n_done), 72'(2));
        check("t3_first2", seen[4], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

        // 4: abort after px 6
        clear_counts();
        stream(0, 0, 6, 1'b0);
        drive(1'b0, 1'b1, '0);
        stream(0, 0, 15, 1'b0);
        idle(3);
        check_frame("t4");

        // 5: start with a coincident pixel drops that pixel
        clear_counts();
        stream(0, 0, 4, 1'b0);
        drive(1'b1, 1'b1, 8'd99);
        stream(0, 0, 15, 1'b0);
        idle(3);
        check_frame("t5");

        // 6: reset mid-frame
        clear_counts();
        stream(0, 0, 9, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_window", window, '0);
        check("t6_rst_valid", 72'(window_valid), 72'(0));
        check("t6_rst_done", 72'(frame_done), 72'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        stream(0, 0, 15, 1'b0);
        idle(3);
        check_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
